// File: rtl/inst_sram_axi_rd.sv
// rtl/inst_sram_axi_rd.sv - fetch-port to AXI4 2-beat INCR read responder
module inst_sram_axi_rd #(
    parameter logic [3:0] AXI_ID   = 4'd0,
    parameter bit         KSEG_MAP = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [63:0] inst_sram_rdata,
    output logic        stallreq,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] addr_r;
    logic        beat;
    logic [63:0] rd_buf;

    // Write port, ID and response are deliberately ignored; the line-offset bits
    // of the fetch address are dropped when the burst address is formed.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wen, inst_sram_wdata, rid, rresp};

    // Unmapped kernel segment (0x8000_0000-0xBFFF_FFFF) folds onto physical low memory.
    function automatic logic [31:0] map_addr(input logic [31:0] va);
        if (KSEG_MAP && (va[31:30] == 2'b10)) begin
            return {3'b000, va[28:0]};
        end
        return va;
    endfunction

    // Request FSM: capture address, run AR handshake, collect beats, one DONE cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            beat    <= 1'b0;
            addr_r  <= 32'h0;
            rd_buf  <= 64'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_sram_en) begin
                        addr_r  <= map_addr(inst_sram_addr);
                        beat    <= 1'b0;
                        arvalid <= 1'b1;
                        state   <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        if (beat) begin
                            rd_buf[63:32] <= rdata;
                        end else begin
                            rd_buf[31:0] <= rdata;
                        end
                        beat <= ~beat;
                        if (rlast) begin
                            rready <= 1'b0;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    arvalid <= 1'b0;
                    rready  <= 1'b0;
                end
            endcase
        end
    end

    assign araddr          = {addr_r[31:3], 3'b000};
    assign arlen           = 8'd1;
    assign arsize          = 3'b010;
    assign arburst         = 2'b01;
    assign arid            = AXI_ID;
    assign inst_sram_rdata = rd_buf;
    assign stallreq        = inst_sram_en & (state != DONE);

endmodule

// File: tb/tb_inst_sram_axi_rd.sv
// tb/tb_inst_sram_axi_rd.sv - self-checking bench for inst_sram_axi_rd
module tb_inst_sram_axi_rd;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;

    logic [63:0] u0_rdata;
    logic        u0_stall;
    logic [3:0]  u0_arid;
    logic [31:0] u0_araddr;
    logic [7:0]  u0_arlen;
    logic [2:0]  u0_arsize;
    logic [1:0]  u0_arburst;
    logic        u0_arvalid;
    logic        u0_rready;

    logic [63:0] u1_rdata;
    logic        u1_stall;
    logic [3:0]  u1_arid;
    logic [31:0] u1_araddr;
    logic [7:0]  u1_arlen;
    logic [2:0]  u1_arsize;
    logic [1:0]  u1_arburst;
    logic        u1_arvalid;
    logic        u1_rready;

    int n_cmp  = 0;
    int n_fail = 0;

    inst_sram_axi_rd #(.AXI_ID(4'd0), .KSEG_MAP(1'b1)) u0 (
        .clk(clk), .resetn(resetn),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(u0_rdata), .stallreq(u0_stall),
        .arid(u0_arid), .araddr(u0_araddr), .arlen(u0_arlen), .arsize(u0_arsize),
        .arburst(u0_arburst), .arvalid(u0_arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(u0_rready)
    );

    inst_sram_axi_rd #(.AXI_ID(4'd5), .KSEG_MAP(1'b0)) u1 (
        .clk(clk), .resetn(resetn),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(u1_rdata), .stallreq(u1_stall),
        .arid(u1_arid), .araddr(u1_araddr), .arlen(u1_arlen), .arsize(u1_arsize),
        .arburst(u1_arburst), .arvalid(u1_arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(u1_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [1:0]  resp;
        int          gap;
        int          ardly;
        logic [31:0] exp_ar0;
        logic [31:0] exp_ar1;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Raise a request from IDLE and carry it through the AR handshake into R.
    task automatic issue(input logic [31:0] addr, input int ardly,
                         input logic [31:0] exp_ar0, input logic [31:0] exp_ar1);
        inst_sram_en   = 1'b1;
        inst_sram_addr = addr;
        #1;
        check("stall_in_idle", {63'h0, u0_stall}, 64'h1);
        check("arvalid_idle", {63'h0, u0_arvalid}, 64'h0);
        step();
        check("arvalid_up", {63'h0, u0_arvalid}, 64'h1);
        check("araddr_kseg", {32'h0, u0_araddr}, {32'h0, exp_ar0});
        check("araddr_flat", {32'h0, u1_araddr}, {32'h0, exp_ar1});
        check("ar_fields", {40'h0, u0_arlen, 5'h0, u0_arsize, 6'h0, u0_arburst},
              {40'h0, 8'd1, 5'h0, 3'd2, 6'h0, 2'd1});
        check("arid", {56'h0, u0_arid, u1_arid}, {56'h0, 4'd0, 4'd5});
        check("rready_in_ar", {63'h0, u0_rready}, 64'h0);
        for (int i = 0; i < ardly; i++) begin
            step();
            check("arvalid_hold", {63'h0, u0_arvalid}, 64'h1);
            check("araddr_hold", {32'h0, u0_araddr}, {32'h0, exp_ar0});
            check("stall_in_ar", {63'h0, u0_stall}, 64'h1);
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("arvalid_down", {63'h0, u0_arvalid}, 64'h0);
        check("rready_up", {63'h0, u0_rready}, 64'h1);
    endtask

    task automatic beat(input logic [31:0] d, input logic last, input logic [1:0] resp);
        rvalid = 1'b1;
        rdata  = d;
        rlast  = last;
        rresp  = resp;
        step();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    // In DONE: check result and single-cycle stall release, then back to IDLE.
    task automatic finish_done(input logic [63:0] exp);
        check("stall_done", {63'h0, u0_stall}, 64'h0);
        check("rdata_done", u0_rdata, exp);
        check("rready_done", {63'h0, u0_rready}, 64'h0);
        step();
        check("stall_after_done", {63'h0, u0_stall}, 64'h1);
        check("arvalid_after_done", {63'h0, u0_arvalid}, 64'h0);
        check("rdata_held", u0_rdata, exp);
        inst_sram_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'hBFBF_FFF8, 32'h1111_1111, 32'h2222_2222, 2'b00, 0, 0, 32'h1FBF_FFF8, 32'hBFBF_FFF8};
        vecs[1] = '{32'h9FC0_0010, 32'hA5A5_0001, 32'h5A5A_0002, 2'b00, 2, 3, 32'h1FC0_0010, 32'h9FC0_0010};
        vecs[2] = '{32'h8000_0004, 32'h0000_00AA, 32'h0000_00BB, 2'b00, 1, 0, 32'h0000_0000, 32'h8000_0000};
        vecs[3] = '{32'h0040_0100, 32'hDEAD_BEEF, 32'h0BAD_F00D, 2'b10, 0, 1, 32'h0040_0100, 32'h0040_0100};
        vecs[4] = '{32'hC000_000C, 32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 0, 0, 32'hC000_0008, 32'hC000_0008};

        resetn          = 1'b0;
        inst_sram_en    = 1'b1;
        inst_sram_addr  = 32'hBFBF_FFF8;
        inst_sram_wen   = 4'hF;
        inst_sram_wdata = 32'hFFFF_FFFF;
        arready         = 1'b0;
        rid             = 4'd3;
        rdata           = 32'h0;
        rresp           = 2'b00;
        rlast           = 1'b0;
        rvalid          = 1'b0;
        step();
        step();
        check("rst_arvalid", {63'h0, u0_arvalid}, 64'h0);
        check("rst_rready", {63'h0, u0_rready}, 64'h0);
        check("rst_rdata", u0_rdata, 64'h0);
        check("rst_stall_follows_en", {63'h0, u0_stall}, 64'h1);
        resetn = 1'b1;

        for (int v = 0; v < 5; v++) begin
            issue(vecs[v].addr, vecs[v].ardly, vecs[v].exp_ar0, vecs[v].exp_ar1);
            beat(vecs[v].b0, 1'b0, vecs[v].resp);
            for (int g = 0; g < vecs[v].gap; g++) begin
                step();
                check("stall_in_gap", {63'h0, u0_stall}, 64'h1);
                check("rready_in_gap", {63'h0, u0_rready}, 64'h1);
            end
            check("stall_before_last", {63'h0, u0_stall}, 64'h1);
            beat(vecs[v].b1, 1'b1, vecs[v].resp);
            finish_done({vecs[v].b1, vecs[v].b0});
            check("flat_rdata", u1_rdata, {vecs[v].b1, vecs[v].b0});
        end

        // en low in IDLE: no request
        step();
        step();
        check("no_req_en_low", {63'h0, u0_arvalid}, 64'h0);

        // Single-beat burst: rlast on beat0 only updates the low word; extra beat ignored
        issue(32'h0000_2000, 0, 32'h0000_2000, 32'h0000_2000);
        beat(32'h7777_7777, 1'b1, 2'b00);
        check("short_stall_done", {63'h0, u0_stall}, 64'h0);
        check("short_rdata", u0_rdata, 64'h9ABC_DEF0_7777_7777);
        inst_sram_en = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hEEEE_EEEE;
        check("extra_rready_done", {63'h0, u0_rready}, 64'h0);
        step();
        check("extra_rready_idle", {63'h0, u0_rready}, 64'h0);
        step();
        rvalid = 1'b0;
        check("extra_not_consumed", u0_rdata, 64'h9ABC_DEF0_7777_7777);

        // Reset mid-burst after beat0, then a fresh burst from beat 0
        issue(32'h0000_3000, 0, 32'h0000_3000, 32'h0000_3000);
        beat(32'h3333_3333, 1'b0, 2'b00);
        resetn = 1'b0;
        #1;
        check("midrst_arvalid", {63'h0, u0_arvalid}, 64'h0);
        check("midrst_rready", {63'h0, u0_rready}, 64'h0);
        check("midrst_rdata", u0_rdata, 64'h0);
        step();
        resetn = 1'b1;
        issue(32'h0000_4008, 0, 32'h0000_4008, 32'h0000_4008);
        beat(32'h4444_4444, 1'b0, 2'b00);
        beat(32'h5555_5555, 1'b1, 2'b00);
        finish_done(64'h5555_5555_4444_4444);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_sram_axi_rd.md
# inst_sram_axi_rd

Read-only responder for the instruction-SRAM-style fetch interface driven by the fetch stage. It converts each enabled, 8-byte-aligned fetch request into one 2-beat AXI4 INCR read burst. It returns both 32-bit instruction words as a 64-bit `inst_sram_rdata`, and holds `stallreq` high until the data is ready. It sits between the fetch stage and the AXI read-channel arbiter in the axi4_v2 core.

## Interface
Parameters:
- `AXI_ID`, default 4'd0: constant value driven on `arid`.
- `KSEG_MAP`, default 1: when 1, addresses in `0x8000_0000`–`0xBFFF_FFFF` map to physical by clearing bits [31:29]; when 0, addresses pass through unchanged.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `inst_sram_en` in 1: fetch request valid.
- `inst_sram_wen` in 4: ignored; the block is read-only.
- `inst_sram_addr` in 32: fetch virtual address; bits [2:0] ignored.
- `inst_sram_wdata` in 32: ignored.
- `inst_sram_rdata` out 64: [31:0] is the word at addr+0, [63:32] is the word at addr+4.
- `stallreq` out 1: freezes the fetch PC while high.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1: AXI4 AR channel.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI4 R channel.

## Operation
- FSM states:
  - IDLE: if `inst_sram_en`=1, latch the mapped address into `addr_r` and go to AR. Otherwise stay in IDLE.
  - AR: hold `arvalid`=1. On `arready`=1, go to R.
  - R: `rready`=1. On each `rvalid`, store `rdata` into buffer word `beat`, then `beat` <= ~`beat`. On `rvalid && rlast`, go to DONE.
  - DONE: for exactly one cycle, then go to IDLE.
- AR channel fields:
  - `araddr` = {`addr_r`[31:3], 3'b000}.
  - `arlen`=8'd1, `arsize`=3'b010, `arburst`=2'b01, `arid`=`AXI_ID`.
  - All fields are stable while `arvalid`=1.
- `stallreq` is combinational: `inst_sram_en` & (state != DONE).
  - It asserts in the same cycle the request appears in IDLE, so the PC does not advance.
- `inst_sram_rdata` is the 64-bit buffer register. Its contents are valid during DONE and held until the next burst overwrites them.
- `rlast` is authoritative: the burst ends on `rlast` even if only one beat arrived. The unwritten buffer word keeps its previous value.
- `rresp` != OKAY: data is still stored and the fetch completes normally. Error signalling is outside this block.
- `rid` is not checked; this block owns its ID exclusively.
- `inst_sram_en` dropping mid-transaction: the burst completes and the FSM passes through DONE. No request is issued from IDLE while `en`=0.
- Address mapping (`KSEG_MAP`=1): if addr[31:30]=2'b10, clear bits [31:29]. Example: 0xBFBF_FFF8 → 0x1FBF_FFF8.

## Timing
- Reset values:
  - state=IDLE, `arvalid`=0, `rready`=0, `beat`=0.
  - `inst_sram_rdata`=64'h0, `addr_r`=0.
  - `stallreq` follows `inst_sram_en` (IDLE).
- Request capture: `arvalid` rises one cycle after IDLE sees `en`=1.
- Best-case latency (`arready` tied 1, R beats back-to-back starting the cycle after the AR handshake), counting from the cycle `en` is seen:
  - c0 IDLE; c1 AR handshake; c2 beat0; c3 beat1 with `rlast`.
  - c4 DONE with `stallreq`=0; c5 IDLE with the new PC.
  - Result: one fetch per 5 cycles.
- A fetch whose PC is registered on the DONE edge is seen in IDLE the following cycle.
- `arvalid` never deasserts before `arready`. `rready` is 0 outside R.
- Asynchronous reset mid-burst: immediately returns to IDLE with `arvalid`/`rready` low. The interconnect is reset by the same `resetn`.
- `rvalid` with `rlast` on beat0 followed by a further `rvalid`: the extra beat arrives in DONE/IDLE with `rready`=0 and is not consumed.

## Test plan
- Reset with `en`=1, addr 0xBFBF_FFF8 → after release, `araddr`=0x1FBF_FFF8, `arlen`=1, `arsize`=2, `arburst`=1. Beats 0x1111_1111, 0x2222_2222 → `rdata`=64'h2222_2222_1111_1111 in DONE, `stallreq`=0 for exactly that cycle.
- `arready` held low 3 cycles → `arvalid` and `araddr` stable throughout; `stallreq`=1 until DONE.
- `rvalid` gaps (beat0, 2 idle cycles, beat1) → correct 64-bit assembly; DONE only on `rlast`.
- `KSEG_MAP`=0, addr 0x8000_0004 → `araddr`=0x8000_0000. `KSEG_MAP`=1, addr 0x9FC0_0010 → `araddr`=0x1FC0_0010.
- `resetn` pulsed low during R after beat0 → `arvalid`=0, `rready`=0 immediately; next request starts a fresh burst with `beat`=0.
- `rresp`=2'b10 on both beats with values 0xDEAD_BEEF / 0x0BAD_F00D → stored and returned unchanged; FSM completes normally.
